// File: rtl/instrument_axil_pkg.sv
// Shared types and constants for the instrument AXI4-Lite register block.
package instrument_axil_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_PHASE_INC = 2'd1;
    localparam logic [1:0] REG_AMPL      = 2'd2;
    localparam logic [1:0] REG_AUX       = 2'd3;

    localparam int NUM_REGS = 4;

    // Byte-lane merge: lanes with a clear strobe keep the old contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/instrument_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit instrument control registers.
// Define INSTR_AXIL_WSTRB_EN to honour wstrb byte enables on writes.
module instrument_axil_regs
    import instrument_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     reg0_out,
    output logic [31:0]                     reg1_out,
    output logic [31:0]                     reg2_out,
    output logic [31:0]                     reg3_out,
    output logic [3:0]                      reg_wr_pulse
);

    logic [31:0] r_regs [NUM_REGS];
    wr_state_t   r_wr_state;
    rd_state_t   r_rd_state;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [3:0]  r_wr_pulse;
    logic [1:0]  r_aw_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic [1:0]  w_commit_idx;
    logic [31:0] w_commit_data;
    logic [3:0]  w_commit_strb;
    logic [31:0] w_commit_word;
    logic [3:0]  w_commit_pulse;
    logic        w_unused;

    assign w_aw_hs = s00_axi_awvalid & r_awready;
    assign w_w_hs  = s00_axi_wvalid & r_wready;
    assign w_ar_hs = s00_axi_arvalid & r_arready;

    // The completing handshake supplies whichever half was not already latched.
    always_comb begin
        w_commit      = 1'b0;
        w_commit_idx  = s00_axi_awaddr[3:2];
        w_commit_data = s00_axi_wdata;
        w_commit_strb = s00_axi_wstrb;
        case (r_wr_state)
            WR_IDLE:    w_commit = w_aw_hs & w_w_hs;
            WR_HAVE_AW: begin
                w_commit     = w_w_hs;
                w_commit_idx = r_aw_idx;
            end
            WR_HAVE_W:  begin
                w_commit      = w_aw_hs;
                w_commit_data = r_wdata;
                w_commit_strb = r_wstrb;
            end
            default:    w_commit = 1'b0;
        endcase
    end

`ifdef INSTR_AXIL_WSTRB_EN
    assign w_commit_word  = merge_bytes(r_regs[w_commit_idx], w_commit_data, w_commit_strb);
    assign w_commit_pulse = (w_commit_strb != 4'b0000) ? (4'b0001 << w_commit_idx) : 4'b0000;
`else
    assign w_commit_word  = w_commit_data;
    assign w_commit_pulse = 4'b0001 << w_commit_idx;
`endif

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_wr_pulse <= 4'b0000;
            r_aw_idx   <= 2'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'b0000;
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= 32'd0;
        end else begin
            r_wr_pulse <= 4'b0000;
            if (w_commit) begin
                r_regs[w_commit_idx] <= w_commit_word;
                r_wr_pulse <= w_commit_pulse;
                r_bvalid   <= 1'b1;
                r_awready  <= 1'b0;
                r_wready   <= 1'b0;
                r_wr_state <= WR_RESP;
            end else begin
                case (r_wr_state)
                    WR_IDLE: begin
                        if (w_aw_hs) begin
                            r_aw_idx   <= s00_axi_awaddr[3:2];
                            r_awready  <= 1'b0;
                            r_wready   <= 1'b1;
                            r_wr_state <= WR_HAVE_AW;
                        end else if (w_w_hs) begin
                            r_wdata    <= s00_axi_wdata;
                            r_wstrb    <= s00_axi_wstrb;
                            r_awready  <= 1'b1;
                            r_wready   <= 1'b0;
                            r_wr_state <= WR_HAVE_W;
                        end else begin
                            r_awready  <= 1'b1;
                            r_wready   <= 1'b1;
                        end
                    end
                    WR_RESP: begin
                        if (s00_axi_bready) begin
                            r_bvalid   <= 1'b0;
                            r_awready  <= 1'b1;
                            r_wready   <= 1'b1;
                            r_wr_state <= WR_IDLE;
                        end
                    end
                    default: r_wr_state <= r_wr_state;
                endcase
            end
        end
    end

    // Read capture uses pre-edge register contents, so a same-edge write is not visible.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata    <= r_regs[s00_axi_araddr[3:2]];
                        r_rvalid   <= 1'b1;
                        r_arready  <= 1'b0;
                        r_rd_state <= RD_RESP;
                    end else begin
                        r_arready  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (s00_axi_rready) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rresp   = RESP_OKAY;
    assign s00_axi_rdata   = r_rdata;
    assign reg_wr_pulse    = r_wr_pulse;

    assign reg0_out = r_regs[REG_CTRL];
    assign reg1_out = r_regs[REG_PHASE_INC];
    assign reg2_out = r_regs[REG_AMPL];
    assign reg3_out = r_regs[REG_AUX];

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0], w_commit_strb, r_wstrb};

endmodule
